// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR fault injector.
package tmr_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, INJECT} state_t;

  localparam logic [1:0] MODE_NONE   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_DOUBLE = 2'b10;
  localparam logic [1:0] MODE_LFSR   = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [1:0] pop3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/tmr_fault_injector_if.sv
// Data/control bundle between a stimulus source and the fault injector.
interface tmr_fault_injector_if #(parameter int CNT_W = 8);
  logic             d_in;
  logic             inject_en;
  logic [1:0]       mode;
  logic             a_out;
  logic             b_out;
  logic             c_out;
  logic             fault_active;
  logic             exp_error;
  logic             exp_bad;
  logic [CNT_W-1:0] fault_cnt;

  modport master (output d_in, inject_en, mode,
                  input  a_out, b_out, c_out, fault_active, exp_error, exp_bad, fault_cnt);
  modport slave  (input  d_in, inject_en, mode,
                  output a_out, b_out, c_out, fault_active, exp_error, exp_bad, fault_cnt);
endinterface

// File: rtl/tmr_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3), steps on adv; exposes the low 3 bits as a lane mask.
module tmr_lfsr8
  import tmr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [2:0] mask
);

  logic [7:0] l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   l <= LFSR_SEED;
    else if (adv) l <= {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  end

  assign mask = l[2:0];

endmodule

// File: rtl/tmr_fault_injector.sv
// Triplicates d_in onto three registered lanes and periodically corrupts some of them.
// Define TMR_INJ_LFSR_EN to enable the pseudo-random lane mask (mode 11).
module tmr_fault_injector
  import tmr_pkg::*;
#(
  parameter int PERIOD = 16,
  parameter int HOLD   = 1,
  parameter int CNT_W  = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  tmr_fault_injector_if.slave  bus
);

  state_t           state;
  logic [15:0]      cnt;
  logic [1:0]       ptr;
  logic [2:0]       mask, mask_nxt, lane_mask, onehot;
  logic             mode_act;
  logic [1:0]       pc;
  logic             a_q, b_q, c_q, fa_q, err_q, bad_q;
  logic [CNT_W-1:0] fault_cnt;
  logic             entering;

  assign entering = bus.inject_en && (state == COUNT) && (cnt == 16'(PERIOD - 1));

`ifdef TMR_INJ_LFSR_EN
  logic [2:0] lfsr_mask;
  tmr_lfsr8 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (entering && (bus.mode == MODE_LFSR)),
    .mask (lfsr_mask)
  );
  assign mode_act = (bus.mode != MODE_NONE);
`else
  assign mode_act = (bus.mode == MODE_SINGLE) || (bus.mode == MODE_DOUBLE);
`endif

  always_comb begin
    onehot   = 3'b001 << ptr;
    mask_nxt = 3'b000;
    case (bus.mode)
      MODE_SINGLE: mask_nxt = onehot;
      MODE_DOUBLE: mask_nxt = ~onehot;
`ifdef TMR_INJ_LFSR_EN
      MODE_LFSR:   mask_nxt = lfsr_mask;
`endif
      default:     mask_nxt = 3'b000;
    endcase
  end

  // cnt counts fault-free cycles in COUNT and hold cycles in INJECT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      mask      <= '0;
      fault_cnt <= '0;
    end else if (!bus.inject_en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= COUNT;
          cnt   <= '0;
        end
        COUNT: begin
          if (cnt == 16'(PERIOD - 1)) begin
            state <= INJECT;
            cnt   <= '0;
            mask  <= mask_nxt;
            if (mode_act && (fault_cnt != {CNT_W{1'b1}}))
              fault_cnt <= fault_cnt + 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        INJECT: begin
          if (cnt == 16'(HOLD - 1)) begin
            state <= COUNT;
            cnt   <= '0;
            ptr   <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lanes and flags share one mask so the flags line up with the corrupted values
  assign lane_mask = (state == INJECT) ? mask : 3'b000;
  assign pc        = pop3(lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {c_q, b_q, a_q} <= '0;
      fa_q            <= 1'b0;
      err_q           <= 1'b0;
      bad_q           <= 1'b0;
    end else begin
      {c_q, b_q, a_q} <= {3{bus.d_in}} ^ lane_mask;
      fa_q            <= |lane_mask;
      err_q           <= (pc == 2'd1) || (pc == 2'd2);
      bad_q           <= (pc >= 2'd2);
    end
  end

  assign bus.a_out        = a_q;
  assign bus.b_out        = b_q;
  assign bus.c_out        = c_q;
  assign bus.fault_active = fa_q;
  assign bus.exp_error    = err_q;
  assign bus.exp_bad      = bad_q;
  assign bus.fault_cnt    = fault_cnt;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// Scoreboard bench: stimulus queues hand-derived per-edge expectations, a negedge monitor checks them.
module tb_tmr_fault_injector;
  logic clk;
  logic rst_n;
  int   edge_n = 0;
  int   checks = 0;
  int   failures = 0;
  int   E;

  typedef struct {
    int         at;
    int         dut;
    logic [2:0] lanes;
    logic [2:0] flags;   // {fault_active, exp_error, exp_bad}
    int         fc;
  } exp_t;

  exp_t q[$];

  tmr_fault_injector_if #(.CNT_W(8)) b0();
  tmr_fault_injector_if #(.CNT_W(2)) b1();

  tmr_fault_injector #(.PERIOD(4), .HOLD(1), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  tmr_fault_injector #(.PERIOD(2), .HOLD(3), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected outputs after absolute edge 'at': lanes = d ^ mask, flags from mask weight
  task automatic push(input int dut, input int at, input logic d, input logic [2:0] m, input int fc);
    exp_t e;
    int   pc;
    pc      = int'(m[0]) + int'(m[1]) + int'(m[2]);
    e.at    = at;
    e.dut   = dut;
    e.lanes = {3{d}} ^ m;
    e.flags = {(pc != 0), (pc == 1 || pc == 2), (pc >= 2)};
    e.fc    = fc;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int dut, input int at, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d edge %0d: got %0h want %0h", nm, dut, at, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= edge_n) begin
      e = q.pop_front();
      if (e.at < edge_n) begin
        chk("stale_entry", e.dut, e.at, edge_n, e.at);
      end else if (e.dut == 0) begin
        chk("lanes", 0, e.at, int'({b0.c_out, b0.b_out, b0.a_out}), int'(e.lanes));
        chk("flags", 0, e.at, int'({b0.fault_active, b0.exp_error, b0.exp_bad}), int'(e.flags));
        chk("fault_cnt", 0, e.at, int'(b0.fault_cnt), e.fc);
      end else begin
        chk("lanes", 1, e.at, int'({b1.c_out, b1.b_out, b1.a_out}), int'(e.lanes));
        chk("flags", 1, e.at, int'({b1.fault_active, b1.exp_error, b1.exp_bad}), int'(e.flags));
        chk("fault_cnt", 1, e.at, int'(b1.fault_cnt), e.fc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    b0.inject_en = 1'b0; b0.d_in = 1'b0; b0.mode = 2'b00;
    b1.inject_en = 1'b0; b1.d_in = 1'b0; b1.mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    push(0, edge_n + 1, 1'b0, 3'b000, 0);
    push(1, edge_n + 1, 1'b0, 3'b000, 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    b0.inject_en = 1'b0; b0.d_in = 1'b0; b0.mode = 2'b00;
    b1.inject_en = 1'b0; b1.d_in = 1'b0; b1.mode = 2'b00;
    do_reset();

    // Single-lane walk a -> b -> c, injections entered at rel edges 4, 9, 14
    E = edge_n;
    b0.d_in = 1'b1; b0.mode = 2'b01; b0.inject_en = 1'b1;
    for (int r = 0; r <= 16; r++)
      push(0, E + 1 + r, 1'b1,
           (r == 5) ? 3'b001 : (r == 10) ? 3'b010 : (r == 15) ? 3'b100 : 3'b000,
           (r < 4) ? 0 : (r < 9) ? 1 : (r < 14) ? 2 : 3);
    repeat (17) @(negedge clk);
    do_reset();

    // Double-lane with d_in=0: {c,b,a}=110 then 101
    E = edge_n;
    b0.d_in = 1'b0; b0.mode = 2'b10; b0.inject_en = 1'b1;
    for (int r = 0; r <= 10; r++)
      push(0, E + 1 + r, 1'b0,
           (r == 5) ? 3'b110 : (r == 10) ? 3'b101 : 3'b000,
           (r < 4) ? 0 : (r < 9) ? 1 : 2);
    repeat (11) @(negedge clk);
    do_reset();

    // LFSR mode from seed 8'h01
    E = edge_n;
    b0.d_in = 1'b1; b0.mode = 2'b11; b0.inject_en = 1'b1;
    for (int r = 0; r <= 16; r++) begin
`ifdef TMR_INJ_LFSR_EN
      push(0, E + 1 + r, 1'b1,
           (r == 5) ? 3'b001 : (r == 10) ? 3'b010 : (r == 15) ? 3'b100 : 3'b000,
           (r < 4) ? 0 : (r < 9) ? 1 : (r < 14) ? 2 : 3);
`else
      push(0, E + 1 + r, 1'b1, 3'b000, 0);
`endif
    end
    repeat (17) @(negedge clk);
    do_reset();

    // HOLD=3 abort in the second inject cycle, then re-enable and saturate the 2-bit counter
    E = edge_n;
    b1.d_in = 1'b1; b1.mode = 2'b01; b1.inject_en = 1'b1;
    for (int r = 0; r <= 5; r++)
      push(1, E + 1 + r, 1'b1, (r == 3 || r == 4) ? 3'b001 : 3'b000, (r < 2) ? 0 : 1);
    repeat (4) @(negedge clk);
    b1.inject_en = 1'b0;
    repeat (2) @(negedge clk);
    E = edge_n;
    b1.inject_en = 1'b1;
    for (int r = 0; r <= 18; r++)
      push(1, E + 1 + r, 1'b1,
           (r >= 3 && r <= 5)   ? 3'b001 :
           (r >= 8 && r <= 10)  ? 3'b010 :
           (r >= 13 && r <= 15) ? 3'b100 :
           (r == 18)            ? 3'b001 : 3'b000,
           (r < 2) ? 1 : (r < 7) ? 2 : 3);
    repeat (19) @(negedge clk);
    do_reset();

    // Async reset while lane a is corrupted, then restart from lane 0
    E = edge_n;
    b0.d_in = 1'b1; b0.mode = 2'b01; b0.inject_en = 1'b1;
    for (int r = 0; r <= 4; r++)
      push(0, E + 1 + r, 1'b1, 3'b000, (r < 4) ? 0 : 1);
    push(0, E + 6, 1'b0, 3'b000, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    E = edge_n;
    for (int r = 0; r <= 5; r++)
      push(0, E + 1 + r, 1'b1, (r == 5) ? 3'b001 : 3'b000, (r < 4) ? 0 : 1);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
